// File: rtl/alu_mdu_seq.sv
// Execute-stage ALU with iterative RV32M-style multiply/divide behind a valid/ready handshake.
// Base ops finish in one cycle; MUL*/DIV*/REM* retire one bit per cycle for XLEN cycles.
module alu_mdu_seq #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [4:0]      op_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic            flush_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            zero_o,
    output logic            busy_o
);
    localparam int SH_W = $clog2(XLEN);

    localparam logic [4:0] OP_ADD  = 5'd0,  OP_SUB    = 5'd1,  OP_SLL   = 5'd2,  OP_SLT  = 5'd3;
    localparam logic [4:0] OP_SLTU = 5'd4,  OP_XOR    = 5'd5,  OP_SRL   = 5'd6,  OP_SRA  = 5'd7;
    localparam logic [4:0] OP_OR   = 5'd8,  OP_AND    = 5'd9;
    localparam logic [4:0] OP_MUL  = 5'd16, OP_MULH   = 5'd17, OP_MULHSU = 5'd18;
    localparam logic [4:0] OP_DIV  = 5'd20, OP_REM    = 5'd22;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

    state_e            state_q;
    logic [XLEN-1:0]   result_q;
    logic [4:0]        op_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   opnd_q;
    logic              neg_q;
    logic              rneg_q;

    logic              sub_op, slt, a_neg, b_neg, is_mul, is_div, b_zero, div_ovf, last;
    logic [XLEN-1:0]   b_eff, base_res, abs_a, abs_b, quot_fix, rem_fix;
    logic [XLEN:0]     add_res, mul_sum, div_rsh, div_trial;
    logic [SH_W-1:0]   shamt;
    logic [2*XLEN-1:0] mul_next, mul_fix, div_next;
    logic              div_ge;

    always_comb begin
        sub_op  = (op_i == OP_SUB) || (op_i == OP_SLT) || (op_i == OP_SLTU);
        b_eff   = sub_op ? ~op_b_i : op_b_i;
        add_res = {1'b0, op_a_i} + {1'b0, b_eff} + {{XLEN{1'b0}}, sub_op};
        slt     = (op_a_i[XLEN-1] ^ op_b_i[XLEN-1]) ? op_a_i[XLEN-1] : add_res[XLEN-1];
        shamt   = op_b_i[SH_W-1:0];
        case (op_i)
            OP_ADD, OP_SUB: base_res = add_res[XLEN-1:0];
            OP_SLL:         base_res = op_a_i << shamt;
            OP_SLT:         base_res = {{(XLEN-1){1'b0}}, slt};
            OP_SLTU:        base_res = {{(XLEN-1){1'b0}}, !add_res[XLEN]};
            OP_XOR:         base_res = op_a_i ^ op_b_i;
            OP_SRL:         base_res = op_a_i >> shamt;
            OP_SRA:         base_res = $signed(op_a_i) >>> shamt;
            OP_OR:          base_res = op_a_i | op_b_i;
            OP_AND:         base_res = op_a_i & op_b_i;
            default:        base_res = '0;
        endcase

        is_mul  = (op_i[4:2] == 3'b100);
        is_div  = (op_i[4:2] == 3'b101);
        a_neg   = op_a_i[XLEN-1] && ((op_i == OP_MUL) || (op_i == OP_MULH) || (op_i == OP_MULHSU)
                                     || (op_i == OP_DIV) || (op_i == OP_REM));
        b_neg   = op_b_i[XLEN-1] && ((op_i == OP_MUL) || (op_i == OP_MULH)
                                     || (op_i == OP_DIV) || (op_i == OP_REM));
        abs_a   = a_neg ? -op_a_i : op_a_i;
        abs_b   = b_neg ? -op_b_i : op_b_i;
        b_zero  = (op_b_i == '0);
        div_ovf = ((op_i == OP_DIV) || (op_i == OP_REM))
                  && (op_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (op_b_i == '1);
    end

    // acc_q holds {partial product} for MUL and {remainder, dividend/quotient} for DIV
    always_comb begin
        last      = (cnt_q == CNT_W'(XLEN - 1));
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
        mul_next  = {mul_sum, acc_q[XLEN-1:1]};
        mul_fix   = neg_q ? -mul_next : mul_next;
        div_rsh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_trial = div_rsh - {1'b0, opnd_q};
        div_ge    = !div_trial[XLEN];
        div_next  = {(div_ge ? div_trial[XLEN-1:0] : div_rsh[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};
        quot_fix  = neg_q ? -div_next[XLEN-1:0] : div_next[XLEN-1:0];
        rem_fix   = rneg_q ? -div_next[2*XLEN-1:XLEN] : div_next[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            op_q     <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
        end else if (flush_i) begin
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (valid_i) begin
                    op_q   <= op_i;
                    cnt_q  <= '0;
                    neg_q  <= a_neg ^ b_neg;
                    rneg_q <= a_neg;
                    if (is_mul) begin
                        acc_q   <= {{XLEN{1'b0}}, abs_b};
                        opnd_q  <= abs_a;
                        state_q <= S_MUL;
                    end else if (is_div) begin
                        if (b_zero) begin
                            result_q <= op_i[1] ? op_a_i : '1;
                            state_q  <= S_DONE;
                        end else if (div_ovf) begin
                            result_q <= op_i[1] ? '0 : op_a_i;
                            state_q  <= S_DONE;
                        end else begin
                            acc_q   <= {{XLEN{1'b0}}, abs_a};
                            opnd_q  <= abs_b;
                            state_q <= S_DIV;
                        end
                    end else begin
                        result_q <= base_res;
                        state_q  <= S_DONE;
                    end
                end
                S_MUL: begin
                    acc_q <= mul_next;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (last) begin
                        result_q <= (op_q[1:0] == 2'b00) ? mul_fix[XLEN-1:0] : mul_fix[2*XLEN-1:XLEN];
                        state_q  <= S_DONE;
                    end
                end
                S_DIV: begin
                    acc_q <= div_next;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (last) begin
                        result_q <= op_q[1] ? rem_fix : quot_fix;
                        state_q  <= S_DONE;
                    end
                end
                S_DONE: if (ready_i) state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ready_o  = (state_q == S_IDLE);
    assign valid_o  = (state_q == S_DONE);
    assign busy_o   = (state_q == S_MUL) || (state_q == S_DIV);
    assign result_o = result_q;
    assign zero_o   = (result_q == '0);
endmodule
